// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl: synchronises, inverts and debounces N active-low key
// lines, latches press events (and release events when the build macro
// KEY_RELEASE_EVT_EN is defined), masks them into a level IRQ, and exposes
// everything through a 4-word register window:
//   addr 0 STATE (RO)  : stable[N-1:0]
//   addr 1 EVENT (W1C) : press[N-1:0], release[16+N-1:16] (release build only)
//   addr 2 MASK  (RW)  : enable[N-1:0], one bit gates press and release of a key
//   addr 3 reserved    : reads 0, writes ignored
// Bus handshake: there is no valid/ready pair. A write is the single cycle
// in which we=1, and it takes effect on that rising edge. rdata is a pure
// combinational decode of addr and is always valid. No back-pressure.
// Parameter constraints: N_KEYS in 1..16, DEBOUNCE_CYCLES >= 2, and
// 2**CNT_W > DEBOUNCE_CYCLES.
module key_debounce_ctrl #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_EVENT = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;

  // Counter value at which a differing input has been seen for the full window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser stages; sync_key is the clean, active-high (pressed=1) level.
  logic [N_KEYS-1:0] sync_meta;
  logic [N_KEYS-1:0] sync_key;

  // Debounced key level and per-key stability counters.
  logic [N_KEYS-1:0] stable;
  logic [CNT_W-1:0]  cnt [N_KEYS];

  // accept[i] marks the edge on which stable[i] takes the new level.
  logic [N_KEYS-1:0] accept;
  logic [N_KEYS-1:0] press_set;
  logic [N_KEYS-1:0] release_set;

  // Software-visible state.
  logic [N_KEYS-1:0] evt_press;
  logic [N_KEYS-1:0] evt_rel;
  logic [N_KEYS-1:0] mask;

  // Decoded write strobes and the W1C clear vector for press flags.
  logic              evt_wr;
  logic              mask_wr;
  logic [N_KEYS-1:0] clr_press;

  // Only some wdata bits are decoded; the rest are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Two-flop synchroniser with inversion so downstream logic sees pressed=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_key  <= '0;
    end else begin
      sync_meta <= ~key_n;
      sync_key  <= sync_meta;
    end
  end

  // A change is accepted when the input differs from stable and the count has run out.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      accept[i] = (sync_key[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign press_set   = accept & sync_key;
  assign release_set = accept & ~sync_key;

  // Per-key debounce counter: any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync_key[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync_key[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign evt_wr    = we && (addr == ADDR_EVENT);
  assign mask_wr   = we && (addr == ADDR_MASK);
  assign clr_press = evt_wr ? wdata[N_KEYS-1:0] : '0;

  // Press flags: W1C clear applied first, then a same-edge set overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_press <= '0;
    end else begin
      evt_press <= (evt_press & ~clr_press) | press_set;
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  logic [N_KEYS-1:0] clr_rel;
  assign clr_rel = evt_wr ? wdata[16 +: N_KEYS] : '0;

  // Release flags: same W1C/set-wins rule as the press flags, in the upper half-word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_rel <= '0;
    end else begin
      evt_rel <= (evt_rel & ~clr_rel) | release_set;
    end
  end
`else
  // Release tracking is not built; the upper half of EVENT reads zero.
  logic unused_release;
  assign unused_release = ^release_set;
  assign evt_rel        = '0;
`endif

  // Interrupt mask register; bits above N_KEYS are not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (mask_wr) begin
      mask <= wdata[N_KEYS-1:0];
    end
  end

  // Level IRQ registered from the current flags and mask (one edge behind them).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |((evt_press | evt_rel) & mask);
    end
  end

  // Combinational read decode; unused bits and the reserved word read zero.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_STATE: rdata[N_KEYS-1:0] = stable;
      ADDR_EVENT: begin
        rdata[N_KEYS-1:0]    = evt_press;
        rdata[16 +: N_KEYS]  = evt_rel;
      end
      ADDR_MASK:  rdata[N_KEYS-1:0] = mask;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Testbench for key_debounce_ctrl (N_KEYS=8, DEBOUNCE_CYCLES=4).
// Directed steps followed by a randomized phase, all checked against a
// reference model that accepts a key change once the synchronised level has
// held the opposite value for DEBOUNCE_CYCLES consecutive edges (sliding window).
module tb_key_debounce_ctrl;

  localparam int N  = 8;
  localparam int DC = 4;

`ifdef KEY_RELEASE_EVT_EN
  localparam logic [31:0] EXP_PRESS_RELEASE = 32'h0002_0002;
`else
  localparam logic [31:0] EXP_PRESS_RELEASE = 32'h0000_0002;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  key_n;
  logic [1:0]    addr;
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;

  always #5 clk = ~clk;

  key_debounce_ctrl #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .addr(addr),
    .we(we),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [N-1:0]  m_d1, m_d2;      // two-edge input delay
  logic [N-1:0]  m_stable;
  logic [N-1:0]  m_mask;
  logic [31:0]   m_evt;
  logic          m_irq;
  logic [N-1:0]  m_win[$];        // last DC synchronised samples

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_stable};
      2'd1:    return m_evt;
      2'd2:    return {24'b0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_d1     = '0;
    m_d2     = '0;
    m_stable = '0;
    m_mask   = '0;
    m_evt    = '0;
    m_irq    = 1'b0;
    m_win.delete();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_now(input string tag);
    #1;
    chk(tag, rdata, m_read(addr));
    chk({tag, "_irq"}, {31'b0, irq}, {31'b0, m_irq});
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: capture the inputs present at the edge, advance the
  // model, then compare the DUT just after the edge.
  task automatic step(input string tag);
    logic [N-1:0] raw, s_now, acc;
    logic         w, all_opp, irq_next;
    logic [1:0]   a;
    logic [31:0]  d, set_bits, clr;
    raw = ~key_n;
    w   = we;
    a   = addr;
    d   = wdata;
    @(posedge clk);
    irq_next = |((m_evt[N-1:0] | m_evt[16 +: N]) & m_mask);
    s_now = m_d2;
    m_d2  = m_d1;
    m_d1  = raw;
    m_win.push_back(s_now);
    if (m_win.size() > DC) void'(m_win.pop_front());
    acc = '0;
    if (m_win.size() == DC) begin
      for (int i = 0; i < N; i++) begin
        all_opp = 1'b1;
        for (int j = 0; j < DC; j++) begin
          if (m_win[j][i] == m_stable[i]) all_opp = 1'b0;
        end
        acc[i] = all_opp;
      end
    end
    set_bits = '0;
    set_bits[N-1:0] = acc & ~m_stable;
`ifdef KEY_RELEASE_EVT_EN
    set_bits[16 +: N] = acc & m_stable;
`endif
    clr   = (w && a == 2'd1) ? d : 32'h0;
    m_evt = (m_evt & ~clr) | set_bits;
    if (w && a == 2'd2) m_mask = d[N-1:0];
    m_stable = m_stable ^ acc;
    m_irq    = irq_next;
    #1;
    chk(tag, rdata, m_read(addr));
    chk({tag, "_irq"}, {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic steps(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input string tag);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step(tag);
    we    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    key_n = '1;
    addr  = 2'd0;
    we    = 1'b0;
    wdata = 32'h0;
    m_reset();

    // 1. Reset state
    #2;
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a);
      #1;
      chk("reset_rdata", rdata, 32'h0);
    end
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Clean press of key 3: accepted exactly 6 edges later
    addr     = 2'd0;
    key_n[3] = 1'b0;
    steps(5, "press3_wait");
    chk("press3_state_early", rdata, 32'h0);
    step("press3_edge");
    chk("press3_state", rdata, 32'h08);
    addr = 2'd1;
    #1;
    chk("press3_event", rdata, 32'h08);
    chk("press3_irq_masked", {31'b0, irq}, 32'h0);

    // 3. Unmask -> irq next edge; W1C clear -> irq drops next edge
    do_write(2'd2, 32'h08, "mask_wr");
    chk("irq_same_edge_as_mask", {31'b0, irq}, 32'h0);
    step("irq_rise");
    chk("irq_after_mask", {31'b0, irq}, 32'h1);
    do_write(2'd1, 32'h08, "evt_clr");
    chk("evt_cleared", rdata, 32'h0);
    step("irq_fall");
    chk("irq_after_clear", {31'b0, irq}, 32'h0);

    // 4. Bouncy key 0 never reaches the acceptance count
    key_n[0] = 1'b0; steps(3, "bounce_lo1");
    key_n[0] = 1'b1; steps(1, "bounce_hi");
    key_n[0] = 1'b0; steps(3, "bounce_lo2");
    key_n[0] = 1'b1; steps(6, "bounce_settle");
    chk("bounce_event", rdata, 32'h0);
    addr = 2'd0;
    check_now("bounce_state");
    chk("bounce_state_const", rdata, 32'h08);

    // 5. W1C clear of bit 5 on the same edge a key-5 press is accepted
    key_n[5] = 1'b0;
    steps(5, "press5_wait");
    do_write(2'd1, 32'h20, "press5_vs_clr");
    chk("set_wins", rdata, 32'h20);

    // 6. Press then release key 1 after clearing everything
    key_n = '1;
    steps(8, "release_all");
    do_write(2'd1, 32'hFFFF_FFFF, "clr_all");
    chk("clr_all_event", rdata, 32'h0);
    key_n[1] = 1'b0; steps(8, "press1");
    key_n[1] = 1'b1; steps(8, "release1");
    chk("press_release_event", rdata, EXP_PRESS_RELEASE);
    do_write(2'd2, 32'h02, "mask1");
    steps(2, "irq_key1");
    chk("irq_key1_const", {31'b0, irq}, 32'h1);
    do_write(2'd1, 32'hFFFF_FFFF, "clr_all2");

    // Reserved word and STATE are write-immune
    do_write(2'd3, 32'hFFFF_FFFF, "wr_reserved");
    chk("reserved_read", rdata, 32'h0);
    do_write(2'd0, 32'hFFFF_FFFF, "wr_state");
    chk("state_unwritten", rdata, 32'h0);

    // Reset mid-count, key held through reset is re-accepted afterwards
    key_n[2] = 1'b0;
    steps(3, "pre_reset_count");
    rst_n = 1'b0;
    m_reset();
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a);
      #1;
      chk("midreset_rdata", rdata, 32'h0);
    end
    chk("midreset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 2'd0;
    steps(5, "post_reset_wait");
    chk("post_reset_early", rdata, 32'h0);
    step("post_reset_accept");
    chk("post_reset_state", rdata, 32'h04);
    addr = 2'd1;
    check_now("post_reset_event");
    chk("post_reset_event_const", rdata, 32'h04);

    // Randomized phase: slow random key toggling plus occasional random writes
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5, 0) == 0) key_n[i] = ~key_n[i];
      end
      addr = 2'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) begin
        do_write(2'($urandom_range(3, 0)), $urandom, "rand_wr");
      end else begin
        step("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
